// File: rtl/base2_kpick_arbiter_pkg.sv
// Shared definitions for the base-2 k-picker arbiter and its response FIFOs.
// Holds the default lane/width constants, the k field width, and the tag and
// response record layouts used between the issue and return sides.
package kpick_pkg;

    localparam int KPICK_DW    = 16;
    localparam int KPICK_N_REQ = 4;
    localparam int KPICK_K_W   = 8;
    localparam int KPICK_RSP_W = KPICK_K_W + 2 * KPICK_DW;
    localparam int KPICK_ID_W  = $clog2(KPICK_N_REQ);

    // Issue tag carried alongside each picker operand.
    typedef struct packed {
        logic                  valid;
        logic [KPICK_ID_W-1:0] id;
    } kpick_tag_t;

    // One picker result as stored in a response FIFO entry.
    typedef struct packed {
        logic [KPICK_K_W-1:0] k;
        logic [KPICK_DW-1:0]  kfp;
        logic [KPICK_DW-1:0]  f;
    } kpick_rsp_t;

endpackage

// File: rtl/base2_kpick_arbiter_rsp_fifo.sv
// kpick_rsp_fifo: first-word-fall-through FIFO with a registered head.
// The head entry lives in an output register; the remaining entries live in a
// small circular buffer. A write into an empty FIFO bypasses the buffer and
// appears on rd_valid_o/rd_data_o the following cycle.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   wr_en_i        write strobe (ignored when full)
//   wr_data_i      write data
//   rd_ready_i     consumer ready; pop = rd_valid_o && rd_ready_i
//   rd_valid_o     FIFO non-empty
//   rd_data_o      head entry
//   full_o         DEPTH entries held
module kpick_rsp_fifo
    import kpick_pkg::*;
#(
    parameter int DW    = KPICK_RSP_W,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_mem_cnt;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;

    logic             w_wr_ok;
    logic             w_pop;
    logic             w_load;
    logic             w_from_mem;
    logic             w_bypass;
    logic             w_to_mem;
    logic [CNT_W-1:0] w_total;

    // Decide where a write lands and whether the head register refills.
    always_comb begin
        w_total    = r_mem_cnt + CNT_W'(r_out_valid);
        w_wr_ok    = wr_en_i && (w_total != CNT_W'(DEPTH));
        w_pop      = r_out_valid && rd_ready_i;
        w_load     = !r_out_valid || w_pop;
        w_from_mem = w_load && (r_mem_cnt != '0);
        // Bypass only when the buffer is empty, so ordering is preserved.
        w_bypass   = w_load && (r_mem_cnt == '0) && w_wr_ok;
        w_to_mem   = w_wr_ok && !w_bypass;
    end

    // Head register, pointers and buffer occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_mem_cnt   <= '0;
        end else begin
            r_out_valid <= w_from_mem || w_bypass || (r_out_valid && !w_pop);
            if (w_from_mem) begin
                r_out_data <= r_mem[r_rptr];
                r_rptr     <= r_rptr + PTR_W'(1);
            end else if (w_bypass) begin
                r_out_data <= wr_data_i;
            end
            if (w_to_mem) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            case ({w_to_mem, w_from_mem})
                2'b10:   r_mem_cnt <= r_mem_cnt + CNT_W'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CNT_W'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

    // Buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_to_mem) begin
            r_mem[r_wptr] <= wr_data_i;
        end
    end

    assign rd_valid_o = r_out_valid;
    assign rd_data_o  = r_out_data;
    assign full_o     = (w_total == CNT_W'(DEPTH));

endmodule

// File: rtl/base2_kpick_arbiter.sv
// base2_kpick_arbiter: shares one fixed-latency base2_k_picker among N_REQ
// requester lanes. A round-robin grant issues at most one FP16 operand per
// cycle; a tag delay line tracks which lane each in-flight result belongs to,
// and returning results are written into per-lane response FIFOs. Per-lane
// credits reserve a FIFO slot before issue because the picker cannot stall.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid_i/req_t_i  per-lane request valid and FP16 operand
//   req_ready_o          one-hot combinational grant
//   pk_valid_o/pk_t_o    registered issue to the picker
//   pk_valid_i, pk_k_i, pk_kfp_i, pk_f_i   picker results
//   rsp_valid_o/rsp_ready_i                per-lane response handshake
//   rsp_k_o, rsp_kfp_o, rsp_f_o            per-lane response data
//   busy_o               any issue in flight or any FIFO non-empty
//   err_o                sticky return-path protocol error
module base2_kpick_arbiter
    import kpick_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int PICK_LAT  = 6,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*DW-1:0]        req_t_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       pk_valid_o,
    output logic [DW-1:0]              pk_t_o,
    input  logic                       pk_valid_i,
    input  logic [KPICK_K_W-1:0]       pk_k_i,
    input  logic [DW-1:0]              pk_kfp_i,
    input  logic [DW-1:0]              pk_f_i,
    output logic [N_REQ-1:0]           rsp_valid_o,
    input  logic [N_REQ-1:0]           rsp_ready_i,
    output logic [N_REQ*KPICK_K_W-1:0] rsp_k_o,
    output logic [N_REQ*DW-1:0]        rsp_kfp_o,
    output logic [N_REQ*DW-1:0]        rsp_f_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int TAG_W  = 1 + ID_W;
    localparam int CRED_W = $clog2(RSP_DEPTH + 1);
    localparam int RSP_W  = KPICK_K_W + 2 * DW;
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(RSP_DEPTH);

    logic [ID_W-1:0]   r_rr_ptr;
    logic [CRED_W-1:0] r_credit     [N_REQ];
    logic [CRED_W-1:0] w_credit_nxt [N_REQ];
    logic              r_pk_valid;
    logic [DW-1:0]     r_pk_t;
    logic [ID_W-1:0]   r_pk_id;
    logic [TAG_W-1:0]  r_tag        [PICK_LAT];
    logic              r_err;
    logic              r_busy;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_grant;
    logic [N_REQ-1:0]  w_accept;
    logic [N_REQ-1:0]  w_pop;
    logic [N_REQ-1:0]  w_full;
    logic [N_REQ-1:0]  w_wr;
    logic              w_acc_any;
    logic [ID_W-1:0]   w_acc_id;
    logic [DW-1:0]     w_acc_t;
    logic              w_tag_valid;
    logic [ID_W-1:0]   w_tag_id;
    logic              w_err;
    logic              w_busy_nxt;
    logic [RSP_W-1:0]  w_rsp_wdata;
    logic [RSP_W-1:0]  w_rsp_rdata  [N_REQ];

    // A lane may be granted only while it still owns a free response slot.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid_i[i] && (r_credit[i] != '0);
        end
    end

    // Round-robin search starting at r_rr_ptr; held off while in reset.
    always_comb begin
        int              v_sum;
        logic [ID_W-1:0] v_sel;
        w_grant   = '0;
        w_acc_any = 1'b0;
        w_acc_id  = '0;
        v_sum     = 0;
        v_sel     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            v_sum = int'(r_rr_ptr) + off;
            v_sel = (v_sum >= N_REQ) ? ID_W'(v_sum - N_REQ) : ID_W'(v_sum);
            if (!w_acc_any && rstn && w_elig[v_sel]) begin
                w_acc_any      = 1'b1;
                w_acc_id       = v_sel;
                w_grant[v_sel] = 1'b1;
            end else begin
                w_acc_any = w_acc_any;
            end
        end
        w_accept = w_grant & req_valid_i;
        w_acc_t  = req_t_i[int'(w_acc_id)*DW +: DW];
    end

    // Issue register toward the picker and round-robin pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pk_valid <= 1'b0;
            r_pk_t     <= '0;
            r_pk_id    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_pk_valid <= w_acc_any;
            if (w_acc_any) begin
                r_pk_t   <= w_acc_t;
                r_pk_id  <= w_acc_id;
                r_rr_ptr <= (w_acc_id == ID_W'(N_REQ - 1)) ? '0 : (w_acc_id + ID_W'(1));
            end
        end
    end

    // Tag delay line fed from the issue register, so its last stage is
    // aligned with the picker's valid_o PICK_LAT cycles later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < PICK_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= {r_pk_valid, r_pk_id};
            for (int s = 1; s < PICK_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tag_valid = r_tag[PICK_LAT-1][TAG_W-1];
    assign w_tag_id    = r_tag[PICK_LAT-1][ID_W-1:0];
    assign w_rsp_wdata = {pk_k_i, pk_kfp_i, pk_f_i};

    // Route a returning result; any tag/valid disagreement drops the data.
    always_comb begin
        w_wr  = '0;
        w_err = 1'b0;
        if (pk_valid_i != w_tag_valid) begin
            w_err = 1'b1;
        end else if (pk_valid_i) begin
            if (w_full[w_tag_id]) begin
                w_err = 1'b1;
            end else begin
                w_wr[w_tag_id] = 1'b1;
            end
        end else begin
            w_err = 1'b0;
        end
    end

    // Credit bookkeeping; busy is derived from the next credit values, since
    // credit below RSP_DEPTH means an entry is in flight or queued.
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_credit_nxt[i] = r_credit[i];
            case ({w_accept[i], w_pop[i]})
                2'b10:   w_credit_nxt[i] = r_credit[i] - CRED_W'(1);
                2'b01:   w_credit_nxt[i] = r_credit[i] + CRED_W'(1);
                default: w_credit_nxt[i] = r_credit[i];
            endcase
            w_busy_nxt = w_busy_nxt | (w_credit_nxt[i] != CRED_FULL);
        end
    end

    // Credit, busy and sticky error registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_credit[i] <= CRED_FULL;
            end
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        kpick_rsp_fifo #(
            .DW    (RSP_W),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk        (clk),
            .rstn       (rstn),
            .wr_en_i    (w_wr[g]),
            .wr_data_i  (w_rsp_wdata),
            .rd_ready_i (rsp_ready_i[g]),
            .rd_valid_o (rsp_valid_o[g]),
            .rd_data_o  (w_rsp_rdata[g]),
            .full_o     (w_full[g])
        );

        assign w_pop[g] = rsp_valid_o[g] & rsp_ready_i[g];
        assign rsp_k_o  [g*KPICK_K_W +: KPICK_K_W] = w_rsp_rdata[g][RSP_W-1 -: KPICK_K_W];
        assign rsp_kfp_o[g*DW +: DW]               = w_rsp_rdata[g][2*DW-1 -: DW];
        assign rsp_f_o  [g*DW +: DW]               = w_rsp_rdata[g][DW-1:0];
    end

    assign req_ready_o = w_grant;
    assign pk_valid_o  = r_pk_valid;
    assign pk_t_o      = r_pk_t;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_base2_kpick_arbiter.sv
// Directed bench for base2_kpick_arbiter with a behavioural model: per-lane
// queues of outstanding results (in flight or queued) with the cycle each
// becomes visible, a round-robin pointer, and a stub picker.
module tb_base2_kpick_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 6;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_t;
    logic [N-1:0]    req_ready_o;
    logic            pk_valid_o;
    logic [DW-1:0]   pk_t_o;
    logic            pk_valid_i;
    logic [7:0]      pk_k_i;
    logic [DW-1:0]   pk_kfp_i;
    logic [DW-1:0]   pk_f_i;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready;
    logic [N*8-1:0]  rsp_k_o;
    logic [N*DW-1:0] rsp_kfp_o;
    logic [N*DW-1:0] rsp_f_o;
    logic            busy_o;
    logic            err_o;
    logic            inj;

    always #5 clk = ~clk;

    base2_kpick_arbiter #(.N_REQ(N), .DW(DW), .PICK_LAT(L), .RSP_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_t_i(req_t),
        .req_ready_o(req_ready_o), .pk_valid_o(pk_valid_o), .pk_t_o(pk_t_o),
        .pk_valid_i(pk_valid_i), .pk_k_i(pk_k_i), .pk_kfp_i(pk_kfp_i), .pk_f_i(pk_f_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_k_o(rsp_k_o),
        .rsp_kfp_o(rsp_kfp_o), .rsp_f_o(rsp_f_o), .busy_o(busy_o), .err_o(err_o)
    );

    // Stub picker result {k, k_fp16, f}: real values for the named operands,
    // an arbitrary but unique mapping otherwise.
    function automatic logic [39:0] pick(input logic [15:0] t);
        case (t)
            16'h4100: pick = {8'h02, 16'h4000, 16'h3800};   //  2.5 -> k=2
            16'hC100: pick = {8'hFD, 16'hC200, 16'h3800};   // -2.5 -> k=-3
            default:  pick = {t[7:0] ^ 8'h5A, t, ~t};
        endcase
    endfunction

    // Stub picker: fixed latency L, reset by the same rstn.
    logic        pv_pipe [L];
    logic [15:0] pt_pipe [L];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < L; s++) begin pv_pipe[s] <= 1'b0; pt_pipe[s] <= 16'h0000; end
        end else begin
            pv_pipe[0] <= pk_valid_o;
            pt_pipe[0] <= pk_t_o;
            for (int s = 1; s < L; s++) begin pv_pipe[s] <= pv_pipe[s-1]; pt_pipe[s] <= pt_pipe[s-1]; end
        end
    end
    assign pk_valid_i = pv_pipe[L-1] | inj;
    assign {pk_k_i, pk_kfp_i, pk_f_i} = pick(pt_pipe[L-1]);

    // Model state
    typedef struct { int vis; logic [39:0] d; } ent_t;
    ent_t        mq [N][$];
    int          m_rr;
    bit          m_pkv;
    logic [15:0] m_pkt;
    bit          m_err;
    int          cyc;
    int          errors;
    int          checks;
    int          gcount [N];
    int          gseq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_empty();
        model_empty = 1'b1;
        for (int l = 0; l < N; l++) if (mq[l].size() != 0) model_empty = 1'b0;
    endfunction

    // One cycle: compare every output against the model, advance the model,
    // then move to the next falling edge. Inputs are set by the caller.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int           g;
        int           j;
        #1;
        exp_ready = '0;
        g = -1;
        for (int off = 0; off < N; off++) begin
            j = (m_rr + off) % N;
            if (g < 0 && req_valid[j] && mq[j].size() < D) g = j;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        chk("pk_valid", 64'(pk_valid_o), 64'(m_pkv));
        if (m_pkv) chk("pk_t", 64'(pk_t_o), 64'(m_pkt));
        exp_rv = '0;
        for (int l = 0; l < N; l++) exp_rv[l] = (mq[l].size() > 0) && (mq[l][0].vis <= cyc);
        chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
        for (int l = 0; l < N; l++) begin
            if (exp_rv[l])
                chk($sformatf("rsp_data%0d", l),
                    64'({rsp_k_o[l*8 +: 8], rsp_kfp_o[l*16 +: 16], rsp_f_o[l*16 +: 16]}),
                    64'(mq[l][0].d));
        end
        chk("busy", 64'(busy_o), 64'(!model_empty()));
        chk("err", 64'(err_o), 64'(m_err));
        // advance model
        for (int l = 0; l < N; l++) if (exp_rv[l] && rsp_ready[l]) void'(mq[l].pop_front());
        if (g >= 0) begin
            ent_t e;
            e.vis = cyc + 2 + L;
            e.d   = pick(req_t[g*16 +: 16]);
            mq[g].push_back(e);
            gcount[g]++;
            gseq.push_back(g);
            m_rr  = (g + 1) % N;
            m_pkv = 1'b1;
            m_pkt = req_t[g*16 +: 16];
        end else begin
            m_pkv = 1'b0;
        end
        if (inj) m_err = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        for (int l = 0; l < N; l++) gcount[l] = 0;
        gseq.delete();
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 60 && !model_empty(); k++) step();
        chk("drain_done", 64'(model_empty()), 64'd1);
        step();
    endtask

    // Assert reset at a falling edge, check all outputs are zero at once.
    task automatic do_reset();
        req_valid = 4'hF;
        rstn = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_pk_valid", 64'(pk_valid_o), 64'd0);
        chk("rst_pk_t", 64'(pk_t_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_data", 64'(rsp_k_o) | 64'(rsp_kfp_o) | 64'(rsp_f_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        for (int l = 0; l < N; l++) mq[l].delete();
        m_rr = 0; m_pkv = 1'b0; m_err = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        req_valid = '0;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int sum;
        errors = 0; checks = 0; cyc = 0;
        rstn = 1'b0; req_valid = '0; req_t = '0; rsp_ready = '1; inj = 1'b0;
        m_rr = 0; m_pkv = 1'b0; m_pkt = 16'h0000; m_err = 1'b0;
        clear_counts();
        @(negedge clk);
        do_reset();

        // Single request on lane 0
        req_t[15:0] = 16'h4100;
        req_valid   = 4'b0001;
        step();
        req_valid = '0;
        #1;
        chk("t1_pk_valid", 64'(pk_valid_o), 64'd1);
        chk("t1_pk_t", 64'(pk_t_o), 64'h4100);
        repeat (7) step();
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid_o), 64'b0001);
        chk("t1_k", 64'(rsp_k_o[7:0]), 64'h02);
        chk("t1_kfp", 64'(rsp_kfp_o[15:0]), 64'h4000);
        chk("t1_f", 64'(rsp_f_o[15:0]), 64'h3800);
        chk("t1_busy_before_pop", 64'(busy_o), 64'd1);
        step();
        #1;
        chk("t1_busy_after_pop", 64'(busy_o), 64'd0);
        chk("t1_rsp_gone", 64'(rsp_valid_o), 64'd0);

        // Round-robin fairness: all lanes valid for 16 cycles
        clear_counts();
        req_valid = 4'hF;
        for (int c = 0; c < 16; c++) begin
            for (int l = 0; l < N; l++) req_t[l*16 +: 16] = 16'h1000 + 16'(l * 256) + 16'(gcount[l]);
            step();
        end
        for (int l = 0; l < N; l++) chk($sformatf("rr_count%0d", l), 64'(gcount[l]), 64'd4);
        for (int k = 0; k < 8; k++) chk("rr_order", 64'(gseq[k]), 64'((1 + k) % 4));
        drain();

        // Credit stall on lane 2 with its response ready held low
        clear_counts();
        req_valid = 4'hF;
        rsp_ready = 4'b1011;
        for (int c = 0; c < 20; c++) begin
            for (int l = 0; l < N; l++) req_t[l*16 +: 16] = 16'h2000 + 16'(l * 256) + 16'(gcount[l]);
            req_t[47:32] = 16'hC100;
            step();
        end
        #1;
        sum = gcount[0] + gcount[1] + gcount[2] + gcount[3];
        chk("stall_lane2_accepts", 64'(gcount[2]), 64'd4);
        chk("stall_total_accepts", 64'(sum), 64'd20);
        chk("stall_ready2_low", 64'(req_ready_o[2]), 64'd0);
        chk("stall_rsp2_valid", 64'(rsp_valid_o[2]), 64'd1);
        chk("stall_k2", 64'(rsp_k_o[23:16]), 64'hFD);
        chk("stall_kfp2", 64'(rsp_kfp_o[47:32]), 64'hC200);
        chk("stall_f2", 64'(rsp_f_o[47:32]), 64'h3800);
        drain();

        // Lane 1 alone: pops and accepts coincide once credits cycle
        clear_counts();
        req_valid = 4'b0010;
        for (int c = 0; c < 24; c++) begin
            req_t[31:16] = 16'h3000 + 16'(gcount[1]);
            step();
        end
        chk("popacc_accepts", 64'(gcount[1]), 64'd12);
        chk("popacc_err", 64'(err_o), 64'd0);
        drain();

        // Spurious picker valid with no tag
        inj = 1'b1;
        step();
        inj = 1'b0;
        #1;
        chk("proto_err_set", 64'(err_o), 64'd1);
        repeat (3) step();
        chk("proto_err_sticky", 64'(err_o), 64'd1);

        // Reset with three issues in flight
        clear_counts();
        req_valid = 4'hF;
        for (int l = 0; l < N; l++) req_t[l*16 +: 16] = 16'h5000 + 16'(l);
        repeat (3) step();
        req_valid = '0;
        repeat (2) step();
        do_reset();
        repeat (20) step();
        clear_counts();
        req_t[63:48] = 16'h4100;
        req_valid = 4'b1000;
        rsp_ready = 4'b0111;
        repeat (6) step();
        chk("post_reset_credits", 64'(gcount[3]), 64'd4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
